// File: rtl/mont_pkg.sv
// Shared sizing and state encodings for the word-serial Montgomery multiplier front/back end.
package mont_pkg;

   localparam int WORD_W = 32;
   localparam int OP_W   = 512;
   localparam int NWORDS = OP_W / WORD_W;
   localparam int IDX_W  = $clog2(NWORDS);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

   typedef enum logic [1:0] {
      LOAD  = 2'd0,
      START = 2'd1,
      WAIT  = 2'd2,
      DRAIN = 2'd3
   } state_t;

   // Operand selector during LOAD; value 3 is unreachable and treated as M.
   localparam logic [1:0] SEL_A = 2'd0;
   localparam logic [1:0] SEL_B = 2'd1;
   localparam logic [1:0] SEL_M = 2'd2;

   typedef logic [NWORDS-1:0][WORD_W-1:0] op_words_t;

endpackage

// File: rtl/mont_word_ser.sv
// Result register: parallel load on capture, word-indexed read-out for the master stream.
module mont_word_ser
   import mont_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load_i,
   input  logic [OP_W-1:0]   data_i,
   input  logic [IDX_W-1:0]  idx_i,
   output logic [WORD_W-1:0] word_o
);

   op_words_t res_q;

   // NOTE: the whole result array is reset so an aborted op never leaks old data onto m_data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_q <= '0;
      end else if (load_i) begin
         // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
         res_q <= data_i;
      end
   end

   assign word_o = res_q[idx_i];

endmodule

// File: rtl/mont_stream_io.sv
// Collects A/B/M as 32-bit words, launches the multiplier, captures its result and streams it back.
module mont_stream_io
   import mont_pkg::*;
(
   input  logic              clk,
   input  logic              resetn,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [WORD_W-1:0] s_data,
   output logic              mont_start,
   output logic [OP_W-1:0]   mont_a,
   output logic [OP_W-1:0]   mont_b,
   output logic [OP_W-1:0]   mont_m,
   input  logic [OP_W-1:0]   mont_result,
   input  logic              mont_done,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [WORD_W-1:0] m_data,
   output logic              busy
);

   state_t           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [IDX_W-1:0] ridx_q, ridx_d;
   logic [1:0]       sel_q, sel_d;
   logic             armed_q, armed_d;
   logic             s_ready_q, s_ready_d;
   op_words_t        a_q, b_q, m_q;

   logic s_hs, m_hs, last_in, last_out, capture;

   assign s_hs     = s_valid & s_ready_q & (state_q == LOAD);
   assign m_hs     = (state_q == DRAIN) & m_ready;
   assign last_in  = s_hs & (idx_q == LAST_IDX) & (sel_q >= SEL_M);
   assign last_out = m_hs & (ridx_q == LAST_IDX);
   // The first WAIT cycle may still see done from the previous op, so capture needs armed_q.
   assign capture  = (state_q == WAIT) & armed_q & mont_done;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= LOAD;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      // NOTE: default assignment first so no path through this block infers a latch.
      state_d = state_q;
      case (state_q)
         LOAD:    if (last_in)  state_d = START;
         START:                 state_d = WAIT;
         WAIT:    if (capture)  state_d = DRAIN;
         DRAIN:   if (last_out) state_d = LOAD;
         default:               state_d = LOAD;
      endcase
   end

   always_comb begin
      mont_start = 1'b0;
      m_valid    = 1'b0;
      busy       = 1'b0;
      case (state_q)
         START: begin
            mont_start = 1'b1;
            busy       = 1'b1;
         end
         WAIT:    busy    = 1'b1;
         DRAIN:   m_valid = 1'b1;
         default: ;
      endcase
   end

   always_comb begin
      idx_d     = idx_q;
      sel_d     = sel_q;
      ridx_d    = ridx_q;
      armed_d   = (state_q == WAIT);
      s_ready_d = (state_d == LOAD);
      if (s_hs) begin
         if (idx_q == LAST_IDX) begin
            idx_d = '0;
            sel_d = (sel_q >= SEL_M) ? SEL_A : sel_q + 2'd1;
         end else begin
            idx_d = idx_q + 1'b1;
         end
      end
      if (m_hs) begin
         ridx_d = (ridx_q == LAST_IDX) ? '0 : ridx_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         idx_q     <= '0;
         sel_q     <= SEL_A;
         ridx_q    <= '0;
         armed_q   <= 1'b0;
         s_ready_q <= 1'b0;
      end else begin
         idx_q     <= idx_d;
         sel_q     <= sel_d;
         ridx_q    <= ridx_d;
         armed_q   <= armed_d;
         s_ready_q <= s_ready_d;
      end
   end

   // Operands stay on the multiplier inputs until the next LOAD overwrites them word by word.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         a_q <= '0;
         b_q <= '0;
         m_q <= '0;
      end else if (s_hs) begin
         case (sel_q)
            SEL_A:   a_q[idx_q] <= s_data;
            SEL_B:   b_q[idx_q] <= s_data;
            default: m_q[idx_q] <= s_data;
         endcase
      end
   end

   assign s_ready = s_ready_q;
   assign mont_a  = a_q;
   assign mont_b  = b_q;
   assign mont_m  = m_q;

   mont_word_ser u_word_ser (
      .clk    (clk),
      .rst_n  (resetn),
      .load_i (capture),
      .data_i (mont_result),
      .idx_i  (ridx_q),
      .word_o (m_data)
   );

endmodule

// File: tb/tb_mont_stream_io.sv
// Directed bench for mont_stream_io: operand load, start pulse, result capture and drain.
module tb_mont_stream_io;
   import mont_pkg::*;

   logic              clk;
   logic              resetn;
   logic              s_valid;
   logic              s_ready;
   logic [WORD_W-1:0] s_data;
   logic              mont_start;
   logic [OP_W-1:0]   mont_a;
   logic [OP_W-1:0]   mont_b;
   logic [OP_W-1:0]   mont_m;
   logic [OP_W-1:0]   mont_result;
   logic              mont_done;
   logic              m_valid;
   logic              m_ready;
   logic [WORD_W-1:0] m_data;
   logic              busy;

   typedef struct {
      logic [OP_W-1:0] a;
      logic [OP_W-1:0] b;
      logic [OP_W-1:0] m;
      logic [OP_W-1:0] res;
      int              gap_pct;
      int              rdy_pct;
      int              done_dly;
      logic [WORD_W-1:0] exp_w0;
      logic [WORD_W-1:0] exp_w1;
   } op_vec_t;

   op_vec_t vecs[4];

   int n_vec = 0;
   int n_fail = 0;
   int start_cnt = 0;
   int sready_viol = 0;

   mont_stream_io dut (
      .clk         (clk),
      .resetn      (resetn),
      .s_valid     (s_valid),
      .s_ready     (s_ready),
      .s_data      (s_data),
      .mont_start  (mont_start),
      .mont_a      (mont_a),
      .mont_b      (mont_b),
      .mont_m      (mont_m),
      .mont_result (mont_result),
      .mont_done   (mont_done),
      .m_valid     (m_valid),
      .m_ready     (m_ready),
      .m_data      (m_data),
      .busy        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (mont_start) start_cnt++;
      if (s_ready && (busy || m_valid)) sready_viol++;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [OP_W-1:0] act, input logic [OP_W-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [OP_W-1:0] pat(input logic [31:0] base, input logic [31:0] step);
      logic [OP_W-1:0] p;
      for (int i = 0; i < NWORDS; i++) p[i*WORD_W +: WORD_W] = base + step * 32'(i);
      return p;
   endfunction

   // Entered and left at 1 time unit after a rising edge.
   task automatic load_op(input logic [3*OP_W-1:0] ops, input int gap);
      int k = 0;
      int cyc = 0;
      int s0;
      bit hs;
      s0 = start_cnt;
      while (k < 3 * NWORDS && cyc < 3000) begin
         s_valid = ($urandom_range(0, 99) >= gap);
         s_data  = s_valid ? ops[k*WORD_W +: WORD_W] : 32'hDEAD_0000 | 32'(k);
         hs = s_valid && s_ready;
         @(posedge clk); #1;
         cyc++;
         if (hs) k++;
      end
      s_valid = 1'b0;
      check("load_words", OP_W'(k), OP_W'(3 * NWORDS));
      check("start_hi", OP_W'(mont_start), OP_W'(1));
      check("s_ready_lo_start", OP_W'(s_ready), OP_W'(0));
      check("mont_a", mont_a, ops[0 +: OP_W]);
      check("mont_b", mont_b, ops[OP_W +: OP_W]);
      check("mont_m", mont_m, ops[2*OP_W +: OP_W]);
      @(posedge clk); #1;
      check("start_lo", OP_W'(mont_start), OP_W'(0));
      check("busy_wait", OP_W'(busy), OP_W'(1));
      check("start_pulses", OP_W'(start_cnt - s0), OP_W'(1));
   endtask

   task automatic drain(input logic [OP_W-1:0] res, input int rdy, input int stop_at);
      int r = 0;
      int cyc = 0;
      bit hs;
      while (r < stop_at && cyc < 4000) begin
         if (m_valid !== 1'b1) begin
            check("drain_valid", OP_W'(m_valid), OP_W'(1));
            break;
         end
         m_ready = ($urandom_range(0, 99) < rdy);
         check("drain_word", OP_W'(m_data), OP_W'(res[r*WORD_W +: WORD_W]));
         hs = m_ready;
         @(posedge clk); #1;
         cyc++;
         if (hs) r++;
      end
      m_ready = 1'b0;
      check("drain_count", OP_W'(r), OP_W'(stop_at));
      if (stop_at == NWORDS) begin
         check("m_valid_drop", OP_W'(m_valid), OP_W'(0));
         check("s_ready_after_drain", OP_W'(s_ready), OP_W'(1));
      end
   endtask

   // Called in the first WAIT cycle, right after load_op.
   task automatic finish_op(input logic [OP_W-1:0] res, input int dly, input int rdy, input int stop_at);
      mont_result = res;
      repeat (dly) @(posedge clk);
      #1;
      mont_done = 1'b1;
      @(posedge clk); #1;
      check("m_valid_rise", OP_W'(m_valid), OP_W'(1));
      // A result change while done stays high must not be recaptured.
      mont_result = ~res;
      drain(res, rdy, stop_at);
      mont_done = 1'b0;
   endtask

   initial begin
      logic [3*OP_W-1:0] ops;
      logic [OP_W-1:0]   res;

      resetn = 1'b0;
      s_valid = 1'b0;
      s_data = '0;
      mont_result = '0;
      mont_done = 1'b0;
      m_ready = 1'b0;

      res = pat(32'h1000_0000, 32'h0101_0101);
      res[31:0] = 32'h0000_0123;
      res[63:32] = 32'h0000_0001;
      vecs[0] = '{a: OP_W'(1), b: OP_W'(2), m: OP_W'(32'hFFFF_FFFF), res: res,
                  gap_pct: 0, rdy_pct: 100, done_dly: 5, exp_w0: 32'h123, exp_w1: 32'h1};
      vecs[1] = '{a: OP_W'(1), b: OP_W'(2), m: OP_W'(32'hFFFF_FFFF), res: res,
                  gap_pct: 30, rdy_pct: 100, done_dly: 1, exp_w0: 32'h123, exp_w1: 32'h1};
      vecs[2] = '{a: OP_W'(1), b: OP_W'(2), m: OP_W'(32'hFFFF_FFFF), res: res,
                  gap_pct: 0, rdy_pct: 50, done_dly: 600, exp_w0: 32'h123, exp_w1: 32'h1};
      vecs[3] = '{a: pat(32'hA5A5_0001, 32'h1111_1111), b: pat(32'h5A5A_FFFF, 32'h0000_0003),
                  m: pat(32'hFFFF_FFF1, 32'hFFFF_FFFF), res: pat(32'hCAFE_0000, 32'h0000_0101),
                  gap_pct: 20, rdy_pct: 70, done_dly: 2, exp_w0: 32'hCAFE_0000, exp_w1: 32'hCAFE_0101};

      // Reset state.
      #23;
      check("rst_s_ready", OP_W'(s_ready), OP_W'(0));
      check("rst_start", OP_W'(mont_start), OP_W'(0));
      check("rst_m_valid", OP_W'(m_valid), OP_W'(0));
      check("rst_busy", OP_W'(busy), OP_W'(0));
      check("rst_mont_a", mont_a, '0);
      check("rst_m_data", OP_W'(m_data), '0);
      @(negedge clk);
      resetn = 1'b1;
      #1;
      check("s_ready_before_edge", OP_W'(s_ready), OP_W'(0));
      @(posedge clk); #1;
      check("s_ready_rise", OP_W'(s_ready), OP_W'(1));

      // Table-driven ops.
      for (int v = 0; v < 4; v++) begin
         ops = {vecs[v].m, vecs[v].b, vecs[v].a};
         load_op(ops, vecs[v].gap_pct);
         finish_op(vecs[v].res, vecs[v].done_dly, vecs[v].rdy_pct, NWORDS);
         check("res_w0", OP_W'(vecs[v].res[31:0]), OP_W'(vecs[v].exp_w0));
         check("res_w1", OP_W'(vecs[v].res[63:32]), OP_W'(vecs[v].exp_w1));
         check("a_held", mont_a, vecs[v].a);
         check("m_held", mont_m, vecs[v].m);
      end

      // Done during LOAD, START and the first WAIT cycle must be ignored.
      mont_done = 1'b1;
      mont_result = pat(32'hBAD0_0000, 32'h1);
      ops = {vecs[3].a, vecs[3].m, vecs[3].b};
      load_op(ops, 0);
      check("stale_done_first_wait", OP_W'(m_valid), OP_W'(0));
      @(posedge clk); #1;
      mont_done = 1'b0;
      check("stale_done_ignored", OP_W'(m_valid), OP_W'(0));
      repeat (4) begin
         @(posedge clk); #1;
         check("no_capture_wait", OP_W'(m_valid), OP_W'(0));
      end
      finish_op(vecs[0].res, 3, 100, NWORDS);

      // Reset in the middle of DRAIN.
      load_op({vecs[0].m, vecs[0].b, vecs[0].a}, 0);
      finish_op(vecs[3].res, 2, 100, 7);
      resetn = 1'b0;
      #1;
      check("mid_rst_m_valid", OP_W'(m_valid), OP_W'(0));
      check("mid_rst_s_ready", OP_W'(s_ready), OP_W'(0));
      check("mid_rst_mont_a", mont_a, '0);
      check("mid_rst_m_data", OP_W'(m_data), '0);
      @(negedge clk);
      resetn = 1'b1;
      @(posedge clk); #1;
      check("s_ready_after_rst", OP_W'(s_ready), OP_W'(1));
      load_op({vecs[3].m, vecs[3].b, vecs[3].a}, 10);
      finish_op(vecs[0].res, 4, 80, NWORDS);

      // Back-to-back ops with s_valid held high through DRAIN.
      load_op({vecs[3].m, vecs[3].b, vecs[3].a}, 0);
      s_valid = 1'b1;
      s_data = vecs[0].a[31:0];
      finish_op(vecs[3].res, 2, 100, NWORDS);
      load_op({vecs[0].m, vecs[0].b, vecs[0].a}, 0);
      finish_op(vecs[0].res, 2, 100, NWORDS);

      check("s_ready_outside_load", OP_W'(sready_viol), OP_W'(0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
